// File: rtl/bip_program_loader_if.sv
// Byte-stream in / program-memory write out bus of bip_program_loader.
// CHK_ERR is present only when LOADER_CHECKSUM_EN is defined.
interface bip_program_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        RX_DATA;
  logic              RX_DONE;
  logic              RELOAD;
  logic [ADDR_W-1:0] PM_ADDR;
  logic [15:0]       PM_DATA;
  logic              PM_WE;
  logic              CPU_RUN;
  logic              LOADED;
  logic              OVERFLOW;
  logic [ADDR_W:0]   WORD_COUNT;
`ifdef LOADER_CHECKSUM_EN
  logic              CHK_ERR;

  modport master (
    input  RX_DATA, RX_DONE, RELOAD,
    output PM_ADDR, PM_DATA, PM_WE, CPU_RUN, LOADED, OVERFLOW, WORD_COUNT, CHK_ERR
  );
  modport slave (
    output RX_DATA, RX_DONE, RELOAD,
    input  PM_ADDR, PM_DATA, PM_WE, CPU_RUN, LOADED, OVERFLOW, WORD_COUNT, CHK_ERR
  );
`else
  modport master (
    input  RX_DATA, RX_DONE, RELOAD,
    output PM_ADDR, PM_DATA, PM_WE, CPU_RUN, LOADED, OVERFLOW, WORD_COUNT
  );
  modport slave (
    output RX_DATA, RX_DONE, RELOAD,
    input  PM_ADDR, PM_DATA, PM_WE, CPU_RUN, LOADED, OVERFLOW, WORD_COUNT
  );
`endif
endinterface

// File: rtl/bip_program_loader.sv
// Assembles big-endian byte pairs into BIP instructions, writes them from address 0 and holds the
// CPU until the halt word or a full memory. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module bip_program_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bip_program_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT_HI = 3'd0,
    S_WAIT_LO = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_DONE    = 3'd3
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [15:0]       r_data,       w_data_nxt;
  logic              r_we,         w_we_nxt;
  logic              r_cpu_run,    w_cpu_run_nxt;
  logic              r_loaded,     w_loaded_nxt;
  logic              r_overflow,   w_overflow_nxt;
  logic [ADDR_W:0]   r_word_count, w_word_count_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_xor,        w_xor_nxt;
  logic              r_chk_err,    w_chk_err_nxt;
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_overflow_nxt   = r_overflow;
    w_word_count_nxt = r_word_count;
`ifdef LOADER_CHECKSUM_EN
    w_xor_nxt        = r_xor;
    w_chk_err_nxt    = r_chk_err;
`endif
    case (r_state)
      S_WAIT_HI: begin
        if (bus.RX_DONE) begin
          w_data_nxt[15:8] = bus.RX_DATA;
          w_state_nxt      = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
          w_xor_nxt        = r_xor ^ bus.RX_DATA;
`endif
        end else begin
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (bus.RX_DONE) begin
          w_data_nxt[7:0] = bus.RX_DATA;
          w_state_nxt     = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
          w_xor_nxt       = r_xor ^ bus.RX_DATA;
`endif
        end else begin
          w_state_nxt = S_WAIT_LO;
        end
      end
      // Bytes arriving here are dropped: the UART cannot deliver one this soon.
      S_WRITE: begin
        w_word_count_nxt = {1'b0, r_addr} + COUNT_ONE;
        if (r_data[15:11] == 5'd0) begin
          w_state_nxt = S_END;
        end else if (r_addr == LAST_ADDR) begin
          w_overflow_nxt = 1'b1;
          w_state_nxt    = S_END;
        end else begin
          w_addr_nxt  = r_addr + ADDR_ONE;
          w_state_nxt = S_WAIT_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.RX_DONE) begin
          w_chk_err_nxt = (bus.RX_DATA != r_xor);
          w_state_nxt   = S_DONE;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
`endif
      S_DONE: begin
        if (bus.RELOAD) begin
          w_overflow_nxt = 1'b0;
          w_addr_nxt     = {ADDR_W{1'b0}};
          w_state_nxt    = S_WAIT_HI;
`ifdef LOADER_CHECKSUM_EN
          w_xor_nxt      = 8'h00;
          w_chk_err_nxt  = 1'b0;
`endif
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_HI;
      end
    endcase
    w_we_nxt     = (w_state_nxt == S_WRITE);
    w_loaded_nxt = (w_state_nxt == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    w_cpu_run_nxt = w_loaded_nxt && !w_chk_err_nxt;
`else
    w_cpu_run_nxt = w_loaded_nxt;
`endif
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_WAIT_HI;
      r_addr       <= {ADDR_W{1'b0}};
      r_data       <= 16'h0000;
      r_we         <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_loaded     <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= 8'h00;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_we         <= w_we_nxt;
      r_cpu_run    <= w_cpu_run_nxt;
      r_loaded     <= w_loaded_nxt;
      r_overflow   <= w_overflow_nxt;
      r_word_count <= w_word_count_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= w_xor_nxt;
      r_chk_err    <= w_chk_err_nxt;
`endif
    end
  end

  assign bus.PM_ADDR    = r_addr;
  assign bus.PM_DATA    = r_data;
  assign bus.PM_WE      = r_we;
  assign bus.CPU_RUN    = r_cpu_run;
  assign bus.LOADED     = r_loaded;
  assign bus.OVERFLOW   = r_overflow;
  assign bus.WORD_COUNT = r_word_count;
`ifdef LOADER_CHECKSUM_EN
  assign bus.CHK_ERR    = r_chk_err;
`endif

endmodule

// File: tb/tb_bip_program_loader.sv
// Bench for bip_program_loader: a full-size (DEPTH=2048) and a tiny (DEPTH=4) instance share one
// byte stream; table rows, directed sequences and random traffic are checked against a load model.
module tb_bip_program_loader;
  localparam int AW   = 11;
  localparam int NDUT = 2;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       reload  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt [NDUT];

  always #5 CLK = ~CLK;

  bip_program_loader_if #(.ADDR_W(AW)) if_a ();
  bip_program_loader_if #(.ADDR_W(AW)) if_b ();
  assign if_a.RX_DATA = rx_data;
  assign if_a.RX_DONE = rx_done;
  assign if_a.RELOAD  = reload;
  assign if_b.RX_DATA = rx_data;
  assign if_b.RX_DONE = rx_done;
  assign if_b.RELOAD  = reload;

  bip_program_loader #(.ADDR_W(AW), .DEPTH(2048)) dut_a (.CLK(CLK), .RESET(RESET), .bus(if_a.master));
  bip_program_loader #(.ADDR_W(AW), .DEPTH(4))    dut_b (.CLK(CLK), .RESET(RESET), .bus(if_b.master));

  // Load model: bytes accepted in this load, write pending, done/overflow/checksum flags.
  int         m_depth [NDUT];
  int         m_nb    [NDUT];
  int         m_wc    [NDUT];
  bit         m_we    [NDUT];
  bit         m_done  [NDUT];
  bit         m_ovf   [NDUT];
  bit         m_chk   [NDUT];
  bit         m_err   [NDUT];
  logic [7:0] m_hi    [NDUT];
  logic [7:0] m_lo    [NDUT];
  logic [7:0] m_x     [NDUT];

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_nb[k] = 0; m_wc[k] = 0; m_we[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
      m_chk[k] = 0; m_err[k] = 0; m_hi[k] = 8'h00; m_lo[k] = 8'h00; m_x[k] = 8'h00;
    end
  endtask

  task automatic end_load(input int k);
`ifdef LOADER_CHECKSUM_EN
    m_chk[k] = 1;
`else
    m_done[k] = 1;
`endif
  endtask

  task automatic model_edge();
    int w;
    for (int k = 0; k < NDUT; k++) begin
      if (m_we[k]) begin
        w = m_nb[k] / 2 - 1;
        m_we[k] = 0;
        m_wc[k] = w + 1;
        if (m_hi[k][7:3] == 5'd0) end_load(k);
        else if (w == m_depth[k] - 1) begin m_ovf[k] = 1; end_load(k); end
      end else if (m_chk[k]) begin
        if (rx_done) begin m_err[k] = (rx_data != m_x[k]); m_chk[k] = 0; m_done[k] = 1; end
      end else if (m_done[k]) begin
        if (reload) begin m_done[k] = 0; m_ovf[k] = 0; m_nb[k] = 0; m_x[k] = 8'h00; m_err[k] = 0; end
      end else if (rx_done) begin
        if (m_nb[k] % 2 == 0) m_hi[k] = rx_data;
        else begin m_lo[k] = rx_data; m_we[k] = 1; end
        m_nb[k]++;
        m_x[k] ^= rx_data;
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic we, input logic [AW-1:0] addr, input logic [15:0] data,
                           input logic run, input logic ld, input logic ovf, input logic [AW:0] wc);
    chk("pm_we", k, 32'(we), 32'(m_we[k]));
    if (m_we[k]) begin
      chk("pm_addr", k, 32'(addr), 32'(m_nb[k] / 2 - 1));
      chk("pm_data", k, 32'(data), 32'({m_hi[k], m_lo[k]}));
    end
    chk("cpu_run", k, 32'(run), 32'(m_done[k] && !m_err[k]));
    chk("loaded", k, 32'(ld), 32'(m_done[k]));
    chk("overflow", k, 32'(ovf), 32'(m_ovf[k]));
    chk("word_count", k, 32'(wc), 32'(m_wc[k]));
  endtask

  task automatic check_model();
    check_dut(0, if_a.PM_WE, if_a.PM_ADDR, if_a.PM_DATA, if_a.CPU_RUN, if_a.LOADED, if_a.OVERFLOW, if_a.WORD_COUNT);
    check_dut(1, if_b.PM_WE, if_b.PM_ADDR, if_b.PM_DATA, if_b.CPU_RUN, if_b.LOADED, if_b.OVERFLOW, if_b.WORD_COUNT);
`ifdef LOADER_CHECKSUM_EN
    chk("chk_err", 0, 32'(if_a.CHK_ERR), 32'(m_err[0]));
    chk("chk_err", 1, 32'(if_b.CHK_ERR), 32'(m_err[1]));
`endif
  endtask

  task automatic check_reset_vals();
    chk("rst_we", 0, 32'(if_a.PM_WE), 32'd0);         chk("rst_we", 1, 32'(if_b.PM_WE), 32'd0);
    chk("rst_addr", 0, 32'(if_a.PM_ADDR), 32'd0);     chk("rst_addr", 1, 32'(if_b.PM_ADDR), 32'd0);
    chk("rst_data", 0, 32'(if_a.PM_DATA), 32'd0);     chk("rst_data", 1, 32'(if_b.PM_DATA), 32'd0);
    chk("rst_run", 0, 32'(if_a.CPU_RUN), 32'd0);      chk("rst_run", 1, 32'(if_b.CPU_RUN), 32'd0);
    chk("rst_loaded", 0, 32'(if_a.LOADED), 32'd0);    chk("rst_loaded", 1, 32'(if_b.LOADED), 32'd0);
    chk("rst_ovf", 0, 32'(if_a.OVERFLOW), 32'd0);     chk("rst_ovf", 1, 32'(if_b.OVERFLOW), 32'd0);
    chk("rst_wc", 0, 32'(if_a.WORD_COUNT), 32'd0);    chk("rst_wc", 1, 32'(if_b.WORD_COUNT), 32'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_model();
    if (if_a.PM_WE) wr_cnt[0]++;
    if (if_b.PM_WE) wr_cnt[1]++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_done = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  typedef struct {
    logic        rxd;
    logic [7:0]  b;
    logic        e_we;
    logic [10:0] e_addr;
    logic [15:0] e_data;
    logic        e_run;
    logic        e_ld;
    logic [11:0] e_wc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mkv(logic rxd, logic [7:0] b, logic we, logic [10:0] a, logic [15:0] d,
                               logic run, logic ld, logic [11:0] wc);
    vec_t v;
    v.rxd = rxd; v.b = b; v.e_we = we; v.e_addr = a; v.e_data = d; v.e_run = run; v.e_ld = ld; v.e_wc = wc;
    return v;
  endfunction

  task automatic tbl_cmp(input int k, input vec_t v, input logic we, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic run, input logic ld, input logic [AW:0] wc);
    chk("tbl_we", k, 32'(we), 32'(v.e_we));
    if (v.e_we) begin
      chk("tbl_addr", k, 32'(a), 32'(v.e_addr));
      chk("tbl_data", k, 32'(d), 32'(v.e_data));
    end
    chk("tbl_run", k, 32'(run), 32'(v.e_run));
    chk("tbl_loaded", k, 32'(ld), 32'(v.e_ld));
    chk("tbl_wc", k, 32'(wc), 32'(v.e_wc));
  endtask

  initial begin
    int wb0;
    m_depth[0] = 2048;
    m_depth[1] = 4;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    model_reset();

    // Program 08 05 / 10 03 / 00 00; first pair uses back-to-back strobes.
    vecs.push_back(mkv(1'b1, 8'h08, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd0));
    vecs.push_back(mkv(1'b1, 8'h05, 1'b1, 11'd0, 16'h0805, 1'b0, 1'b0, 12'd0));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd1));
    vecs.push_back(mkv(1'b1, 8'h10, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd1));
    vecs.push_back(mkv(1'b1, 8'h03, 1'b1, 11'd1, 16'h1003, 1'b0, 1'b0, 12'd1));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd2));
    vecs.push_back(mkv(1'b1, 8'h00, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd2));
    vecs.push_back(mkv(1'b1, 8'h00, 1'b1, 11'd2, 16'h0000, 1'b0, 1'b0, 12'd2));
`ifdef LOADER_CHECKSUM_EN
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 12'd3));
    vecs.push_back(mkv(1'b1, 8'h1E, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b1, 12'd3));
`else
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b1, 12'd3));
`endif

    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals();
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rx_data = vecs[i].b;
      rx_done = vecs[i].rxd;
      step();
      rx_done = 1'b0;
      tbl_cmp(0, vecs[i], if_a.PM_WE, if_a.PM_ADDR, if_a.PM_DATA, if_a.CPU_RUN, if_a.LOADED, if_a.WORD_COUNT);
      tbl_cmp(1, vecs[i], if_b.PM_WE, if_b.PM_ADDR, if_b.PM_DATA, if_b.CPU_RUN, if_b.LOADED, if_b.WORD_COUNT);
      chk("tbl_ovf", 0, 32'(if_a.OVERFLOW), 32'd0);
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum of 08 05 00 00 is 0D: a match runs the CPU, a wrong byte blocks it.
    do_reload();
    send(8'h08); send(8'h05); idle(1); send(8'h00); send(8'h00); idle(1); send(8'h0D);
    chk("cs_run", 0, 32'(if_a.CPU_RUN), 32'd1);
    chk("cs_err", 0, 32'(if_a.CHK_ERR), 32'd0);
    do_reload();
    send(8'h08); send(8'h05); idle(1); send(8'h00); send(8'h00); idle(1); send(8'h0C);
    chk("cs_bad_run", 0, 32'(if_a.CPU_RUN), 32'd0);
    chk("cs_bad_err", 0, 32'(if_a.CHK_ERR), 32'd1);
    chk("cs_bad_loaded", 0, 32'(if_a.LOADED), 32'd1);
    do_reload();
    chk("cs_reload_err", 0, 32'(if_a.CHK_ERR), 32'd0);
    send(8'h00); send(8'h00); idle(1); send(8'h00);
`else
    // Overflow: four non-halt words fill the DEPTH=4 instance; a fifth pair is not written.
    do_reload();
    chk("reload_run", 0, 32'(if_a.CPU_RUN), 32'd0);
    wb0 = wr_cnt[1];
    for (int i = 0; i < 4; i++) begin send(8'h08); send(8'h01); idle(1); end
    chk("ovf_writes", 1, 32'(wr_cnt[1] - wb0), 32'd4);
    chk("ovf_flag", 1, 32'(if_b.OVERFLOW), 32'd1);
    chk("ovf_wc", 1, 32'(if_b.WORD_COUNT), 32'd4);
    chk("ovf_run", 1, 32'(if_b.CPU_RUN), 32'd1);
    wb0 = wr_cnt[1];
    send(8'h08); send(8'h01); idle(1);
    chk("ovf_no_write", 1, 32'(wr_cnt[1] - wb0), 32'd0);
    chk("big_wc5", 0, 32'(if_a.WORD_COUNT), 32'd5);
    send(8'h00); send(8'h00); idle(1);
    chk("big_wc6", 0, 32'(if_a.WORD_COUNT), 32'd6);
    chk("big_ovf", 0, 32'(if_a.OVERFLOW), 32'd0);

    // Reset after the first byte of the second word aborts the load.
    do_reload();
    send(8'h08); send(8'h05); idle(1); send(8'h08);
    #2 RESET = 1'b0;
    #1 check_reset_vals();
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    send(8'h00); send(8'h00);
    chk("rst_reload_we", 0, 32'(if_a.PM_WE), 32'd1);
    chk("rst_reload_addr", 0, 32'(if_a.PM_ADDR), 32'd0);
    chk("rst_reload_data", 0, 32'(if_a.PM_DATA), 32'h0000);
    idle(1);
    chk("rst_reload_wc", 0, 32'(if_a.WORD_COUNT), 32'd1);

    // RELOAD from DONE, then 18 07 / 00 00.
    do_reload();
    chk("reload_drop_run", 0, 32'(if_a.CPU_RUN), 32'd0);
    chk("reload_drop_ld", 0, 32'(if_a.LOADED), 32'd0);
    send(8'h18); send(8'h07);
    chk("rl_addr0", 0, 32'(if_a.PM_ADDR), 32'd0);
    chk("rl_data0", 0, 32'(if_a.PM_DATA), 32'h1807);
    idle(1); send(8'h00); send(8'h00);
    chk("rl_addr1", 0, 32'(if_a.PM_ADDR), 32'd1);
    idle(1);
    chk("rl_wc", 0, 32'(if_a.WORD_COUNT), 32'd2);
    chk("rl_run", 0, 32'(if_a.CPU_RUN), 32'd1);

    // Byte during WRITE is dropped; RELOAD while loading is ignored.
    do_reload();
    reload = 1'b1; send(8'h08); reload = 1'b0;
    send(8'h05); send(8'h33); send(8'h00); send(8'h00);
    chk("drop_addr", 0, 32'(if_a.PM_ADDR), 32'd1);
    chk("drop_data", 0, 32'(if_a.PM_DATA), 32'h0000);
    idle(1);
    chk("drop_wc", 0, 32'(if_a.WORD_COUNT), 32'd2);
`endif

    // Random traffic against the model, halt-ish high bytes biased in.
    for (int i = 0; i < 3000; i++) begin
      rx_done = ($urandom_range(0, 1) == 1);
      rx_data = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      reload  = ($urandom_range(0, 5) == 0);
      step();
    end
    rx_done = 1'b0;
    reload  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bip_program_loader.md
# bip_program_loader

Loads a BIP program into instruction memory from a byte stream and holds the processor stopped until the load is done. It sits between the UART receiver and the program-memory write port. It assembles big-endian byte pairs into 16-bit instructions and writes them at sequential addresses from 0. The load ends when it writes the halt word (opcode 0) or fills the memory. It then releases the CPU and records the instruction count.

## Interface
- ADDR_W, 11: program-memory address width; matches the 11-bit PC.
- DEPTH, 2048: number of words in program memory; must be ≤ 2^ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- RX_DATA  input  8  received byte; valid only while RX_DONE=1.
- RX_DONE  input  1  one-cycle strobe marking a valid RX_DATA.
- RELOAD  input  1  one-cycle request to start a new load; honoured only in DONE.
- PM_ADDR  output  ADDR_W  program-memory write address.
- PM_DATA  output  16  instruction word to write.
- PM_WE  output  1  write enable; one-cycle pulse per instruction.
- CPU_RUN  output  1  0 holds the processor in reset; 1 lets it execute.
- LOADED  output  1  high in DONE.
- OVERFLOW  output  1  the load ended on a full memory with no halt word.
- WORD_COUNT  output  ADDR_W+1  number of words written in the last load, halt word included.

## Operation
- States: WAIT_HI, WAIT_LO, WRITE, DONE (plus CHECK when LOADER_CHECKSUM_EN is defined).
- Reset: state=WAIT_HI, address counter=0, PM_WE=0, PM_ADDR=0, PM_DATA=0, CPU_RUN=0, LOADED=0, OVERFLOW=0, WORD_COUNT=0.
- WAIT_HI: on RX_DONE, latch RX_DATA into PM_DATA[15:8] and go to WAIT_LO.
- WAIT_LO: on RX_DONE, latch RX_DATA into PM_DATA[7:0] and go to WRITE.
- WRITE (exactly one cycle):
  - PM_WE=1 with PM_ADDR equal to the address counter.
  - If PM_DATA[15:11]==0, the word is the halt word: go to DONE.
  - Else if address counter == DEPTH-1: set OVERFLOW=1 and go to DONE.
  - Else: increment the address counter and go to WAIT_HI.
  - In every case WORD_COUNT takes address counter + 1.
- DONE: CPU_RUN=1, LOADED=1, and RX bytes are ignored. On RELOAD:
  - clear CPU_RUN, LOADED and OVERFLOW;
  - clear the address counter;
  - go to WAIT_HI.
  - WORD_COUNT keeps its value until the next WRITE.
- RX_DONE arriving during WRITE is dropped; the upstream UART byte time makes this impossible in normal use.
- RELOAD outside DONE is ignored.
- Reset asserted at any point aborts the load. Words already written stay in memory; all outputs return to their reset values immediately.
- Arithmetic: the address counter is ADDR_W bits and never wraps, because the overflow check stops it at DEPTH-1. WORD_COUNT is one bit wider so DEPTH itself is representable.

## Timing
- PM_WE goes high on the first rising edge after the RX_DONE that carries the low byte, and stays high for exactly one cycle.
- PM_ADDR and PM_DATA are registered and stable for the whole PM_WE cycle.
- CPU_RUN and LOADED rise on the edge that ends the final WRITE cycle, one cycle after the last PM_WE. The processor therefore never fetches from a half-written memory.
- Back-to-back RX_DONE strobes (one per cycle) are accepted in WAIT_HI and WAIT_LO. The minimum spacing between instruction pairs is 3 cycles.
- There are no combinational paths from inputs to outputs.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the halt or overflow WRITE, the FSM enters CHECK and waits for one more byte.
  - That byte must equal the XOR of every program byte received in this load.
  - On a match, go to DONE with CPU_RUN=1.
  - On a mismatch, go to DONE with the added output CHK_ERR=1 and CPU_RUN held at 0.
  - CHK_ERR resets to 0 and clears on RELOAD.
- LOADER_CHECKSUM_EN undefined: there is no CHECK state and no CHK_ERR port; WRITE goes straight to DONE.

## Test plan
- Reset, then bytes 08 05, 10 03, 00 00 -> PM_WE pulses with (addr 0, 0805), (1, 1003), (2, 0000); then CPU_RUN=1, LOADED=1, WORD_COUNT=3, OVERFLOW=0.
- DEPTH=4 build; send 4 non-halt words 0801 -> 4 writes at addresses 0..3; OVERFLOW=1, WORD_COUNT=4, CPU_RUN=1; a fifth byte pair causes no write.
- Reset pulled low after byte 08 of the second word -> all outputs at reset values that cycle; a subsequent 00 00 writes 0000 at address 0.
- In DONE, send RELOAD then 18 07, 00 00 -> CPU_RUN drops the cycle after RELOAD; writes at addresses 0 and 1; WORD_COUNT=2.
- RX_DONE strobes in consecutive cycles with 08, 05 -> PM_WE exactly 1 cycle after the second strobe, PM_DATA=0805.
- LOADER_CHECKSUM_EN defined: send 08 05, 00 00, checksum 0D -> CPU_RUN=1, CHK_ERR=0. Same stream with checksum 0C -> CHK_ERR=1, CPU_RUN=0.
